uart_transmitter: RTL and testbench



---
 rtl/uart_transmitter.sv | 147 ++++++++++++++
 tb/tb_uart_transmitter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART serialiser: 8N/8E/8O with 1 or 2 stop bits; tx falls one cycle after acceptance, frame = (9+parity+stop)*CLKS_PER_BIT cycles.
// Backpressure: tx_ready only in IDLE or the final stop-bit cycle, so a held tx_valid chains frames with no idle gap.
module uart_transmitter #(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_complete
);

    localparam int                CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic              PAR_EN    = (PARITY_EN != 0);
    localparam logic              PAR_ODD   = (PARITY_ODD != 0);
    localparam logic              STOP_LAST = (STOP_BITS == 2);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [2:0]       bit_cnt, bit_cnt_nxt;
    logic             stop_cnt, stop_cnt_nxt;
    logic [7:0]       shift_reg, shift_nxt;
    logic             parity_bit, parity_nxt;
    logic             tx_nxt;
    logic             bit_done;
    logic             last_stop;
    logic             accept;

    assign bit_done    = (cnt == CNT_LAST);
    assign last_stop   = (state == STOP) && bit_done && (stop_cnt == STOP_LAST);
    assign tx_ready    = !reset && ((state == IDLE) || last_stop);
    assign tx_complete = !reset && last_stop;
    assign tx_busy     = (state != IDLE);
    assign accept      = tx_valid && tx_ready;

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt + CNT_W'(1);
        bit_cnt_nxt  = bit_cnt;
        stop_cnt_nxt = stop_cnt;
        shift_nxt    = shift_reg;
        parity_nxt   = parity_bit;
        tx_nxt       = 1'b1;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (accept) begin
                    state_nxt  = START;
                    shift_nxt  = tx_data;
                    parity_nxt = (^tx_data) ^ PAR_ODD;
                end
            end
            START: begin
                if (bit_done) begin
                    state_nxt   = DATA;
                    cnt_nxt     = '0;
                    bit_cnt_nxt = 3'd0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    cnt_nxt   = '0;
                    shift_nxt = {1'b0, shift_reg[7:1]};
                    if (bit_cnt == 3'd7) begin
                        state_nxt    = PAR_EN ? PARITY : STOP;
                        stop_cnt_nxt = 1'b0;
                    end else begin
                        bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_nxt    = STOP;
                    cnt_nxt      = '0;
                    stop_cnt_nxt = 1'b0;
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_nxt = '0;
                    if (stop_cnt == STOP_LAST) begin
                        // Back-to-back byte reuses the final stop cycle as its acceptance cycle
                        if (accept) begin
                            state_nxt  = START;
                            shift_nxt  = tx_data;
                            parity_nxt = (^tx_data) ^ PAR_ODD;
                        end else begin
                            state_nxt = IDLE;
                        end
                    end else begin
                        stop_cnt_nxt = 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase

        // Line level is derived from the upcoming state so tx can be a plain register
        case (state_nxt)
            START:   tx_nxt = 1'b0;
            DATA:    tx_nxt = shift_nxt[0];
            PARITY:  tx_nxt = parity_nxt;
            default: tx_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge system_clk) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= 3'd0;
            stop_cnt   <= 1'b0;
            shift_reg  <= 8'h00;
            parity_bit <= 1'b0;
            tx         <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            stop_cnt   <= stop_cnt_nxt;
            shift_reg  <= shift_nxt;
            parity_bit <= parity_nxt;
            tx         <= tx_nxt;
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: three line formats side by side, compared each cycle against a frame-level reference model.
module tb_uart_transmitter;

    localparam int C = 4;
    localparam int N = 3;
    localparam int PE [N] = '{0, 1, 1};
    localparam int PO [N] = '{0, 0, 1};
    localparam int SB [N] = '{1, 2, 2};

    logic         system_clk = 1'b0;
    logic         reset      = 1'b1;
    logic         tx_valid [N];
    logic [7:0]   tx_data  [N];
    logic [N-1:0] tx_ready;
    logic [N-1:0] tx;
    logic [N-1:0] tx_busy;
    logic [N-1:0] tx_complete;

    always #5 system_clk = ~system_clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        uart_transmitter #(
            .CLKS_PER_BIT(C),
            .PARITY_EN   (PE[g]),
            .PARITY_ODD  (PO[g]),
            .STOP_BITS   (SB[g])
        ) dut (
            .system_clk (system_clk),
            .reset      (reset),
            .tx_data    (tx_data[g]),
            .tx_valid   (tx_valid[g]),
            .tx_ready   (tx_ready[g]),
            .tx         (tx[g]),
            .tx_busy    (tx_busy[g]),
            .tx_complete(tx_complete[g])
        );
    end

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: cycles elapsed since acceptance (0 = idle) plus the frame as a bit list
    int          pos   [N];
    int          flen  [N];
    logic [11:0] frame [N];
    bit          acc   [N];
    logic [7:0]  qbuf  [N][16];
    int          qh    [N];
    int          qt    [N];

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chk_bound(input string tag, input int pending);
        n_asserts++;
        assert (pending === 0) else begin
            n_fail++;
            $error("FAIL %s observed=%0d still pending expected=0", tag, pending);
        end
    endtask

    task automatic cycle();
        for (int i = 0; i < N; i++) begin
            bit rdy;
            rdy    = !reset && (pos[i] == 0 || pos[i] == flen[i]);
            acc[i] = tx_valid[i] && rdy;
            if (reset) begin
                pos[i] = 0;
            end else if (acc[i]) begin
                pos[i]          = 1;
                frame[i]        = '1;
                frame[i][0]     = 1'b0;
                frame[i][8:1]   = tx_data[i];
                if (PE[i] != 0) frame[i][9] = (^tx_data[i]) ^ (PO[i] != 0);
            end else if (pos[i] == flen[i]) begin
                pos[i] = 0;
            end else if (pos[i] != 0) begin
                pos[i]++;
            end
        end
        @(posedge system_clk);
        @(negedge system_clk);
        for (int i = 0; i < N; i++) begin
            logic e_tx;
            e_tx = (pos[i] == 0) ? 1'b1 : frame[i][(pos[i] - 1) / C];
            chk($sformatf("tx[%0d]", i), tx[i], e_tx);
            chk($sformatf("tx_busy[%0d]", i), tx_busy[i], pos[i] != 0);
            chk($sformatf("tx_complete[%0d]", i), tx_complete[i], !reset && pos[i] == flen[i]);
            chk($sformatf("tx_ready[%0d]", i), tx_ready[i],
                !reset && (pos[i] == 0 || pos[i] == flen[i]));
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic push_all(input logic [7:0] b);
        for (int i = 0; i < N; i++) begin
            if (qh[i] == qt[i]) begin
                qh[i] = 0;
                qt[i] = 0;
            end
            qbuf[i][qt[i]] = b;
            qt[i]++;
        end
    endtask

    function automatic int pending_bytes();
        int s = 0;
        for (int i = 0; i < N; i++) s += qt[i] - qh[i];
        return s;
    endfunction

    // Presents queued bytes with tx_valid held until each one is accepted
    task automatic drain(input int max_cycles);
        int k = 0;
        while (pending_bytes() != 0 && k < max_cycles) begin
            for (int i = 0; i < N; i++) begin
                tx_valid[i] = (qh[i] != qt[i]);
                tx_data[i]  = (qh[i] != qt[i]) ? qbuf[i][qh[i]] : tx_data[i];
            end
            cycle();
            for (int i = 0; i < N; i++) if (acc[i]) qh[i]++;
            k++;
        end
        for (int i = 0; i < N; i++) tx_valid[i] = 1'b0;
        chk_bound("drain_timeout", pending_bytes());
        for (int i = 0; i < N; i++) qh[i] = qt[i];
    endtask

    task automatic wait_idle(input int max_cycles);
        int k    = 0;
        int busy = 1;
        while (busy != 0 && k < max_cycles) begin
            cycle();
            busy = 0;
            for (int i = 0; i < N; i++) if (pos[i] != 0) busy++;
            k++;
        end
        chk_bound("idle_timeout", busy);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            pos[i]      = 0;
            flen[i]     = (1 + 8 + PE[i] + SB[i]) * C;
            frame[i]    = '1;
            acc[i]      = 1'b0;
            qh[i]       = 0;
            qt[i]       = 0;
            tx_valid[i] = 1'b0;
            tx_data[i]  = 8'h00;
        end

        // Reset held three cycles, then release
        reset = 1'b1;
        run(3);
        reset = 1'b0;
        run(2);

        // Basic frame
        push_all(8'hA5);
        drain(10);
        wait_idle(100);
        run(3);

        // Back-to-back with tx_valid held
        push_all(8'h00);
        push_all(8'hFF);
        drain(200);
        wait_idle(100);

        // Parity sense check byte
        push_all(8'h07);
        drain(10);
        wait_idle(100);

        // Data stability and ignored tx_valid while busy
        push_all(8'h3C);
        drain(10);
        run(4);
        for (int i = 0; i < N; i++) begin
            tx_data[i]  = 8'hC3;
            tx_valid[i] = 1'b1;
        end
        run(20);
        for (int i = 0; i < N; i++) tx_valid[i] = 1'b0;
        wait_idle(100);

        // Reset during data bit 3, then a clean frame
        push_all(8'h96);
        drain(10);
        run(16);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        run(2);
        push_all(8'h55);
        drain(10);
        wait_idle(100);

        // Randomised bytes, some chained back-to-back, random gaps
        for (int r = 0; r < 10; r++) begin
            push_all(8'($urandom));
            if ($urandom_range(0, 1) == 1) push_all(8'($urandom));
            drain(300);
            if (r % 2 == 1) wait_idle(100);
            run($urandom_range(0, 5));
        end
        wait_idle(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
